// File: rtl/fp_add_arbiter.sv
// Two-requester arbiter in front of one shared combinational IEEE-754 single adder.
// Round-robin on contention; one operation in flight, result held until the consumer takes it.

module fp_add_core (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res
);
  logic        swap, sub, sticky, round_up, a_nan, b_nan, a_inf, b_inf;
  logic [31:0] x, y;
  logic [7:0]  ex, ey, d, e_field;
  logic [26:0] mx, my, my_shift, my_aln, m_norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [8:0]  e_norm, e_fin, shift;
  logic [24:0] mant_rnd;

  always_comb begin
    a_nan = (&a[30:23]) & (|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    a_inf = (&a[30:23]) & ~(|a[22:0]);
    b_inf = (&b[30:23]) & ~(|b[22:0]);

    // x always carries the larger magnitude so the aligned subtraction never borrows
    swap = b[30:0] > a[30:0];
    x = swap ? b : a;
    y = swap ? a : b;
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    d = ex - ey;
    mx = {x[30:23] != 8'd0, x[22:0], 3'b000};
    my = {y[30:23] != 8'd0, y[22:0], 3'b000};
    my_shift = my >> d;
    sticky = (my_shift << d) != my;
    my_aln = {my_shift[26:1], my_shift[0] | sticky};
    sub = x[31] ^ y[31];
    sum = sub ? ({1'b0, mx} - {1'b0, my_aln}) : ({1'b0, mx} + {1'b0, my_aln});

    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    // left shift is capped so the exponent stops at 1 and the result falls into the subnormal range
    e_norm = {1'b0, ex};
    shift = 9'd0;
    m_norm = sum[26:0];
    if (sum[27]) begin
      m_norm = {sum[27:2], sum[1] | sum[0]};
      e_norm = e_norm + 9'd1;
    end else begin
      shift = ({4'd0, lz} < (e_norm - 9'd1)) ? {4'd0, lz} : (e_norm - 9'd1);
      m_norm = sum[26:0] << shift;
      e_norm = e_norm - shift;
    end

    round_up = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
    mant_rnd = {1'b0, m_norm[26:3]} + {24'd0, round_up};
    e_fin = e_norm + {8'd0, mant_rnd[24]};
    e_field = (mant_rnd[24] | mant_rnd[23]) ? e_fin[7:0] : 8'd0;

    res = {x[31], e_field, mant_rnd[22:0]};
    if (e_fin >= 9'd255) res = {x[31], 8'hFF, 23'd0};
    if (sum == 28'd0) res = {x[31] & y[31], 31'd0};
    if (a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31]))) res = 32'h7FC00000;
    else if (a_inf) res = a;
    else if (b_inf) res = b;
  end
endmodule

module fp_add_arbiter #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_res,
  output logic        busy,
  output logic [15:0] ops_done
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t      state_reg;
  logic [31:0] op_a_reg, op_b_reg, res_reg, core_res;
  logic        id_reg, last_grant_reg, resp_valid_reg, grant1, idle;
  logic [15:0] ops_done_reg;

  fp_add_core u_core (.a(op_a_reg), .b(op_b_reg), .res(core_res));

  // requester 1 wins alone, or on contention when requester 0 was served last
  assign grant1     = req1_valid & (~req0_valid | ~last_grant_reg);
  assign idle       = (state_reg == IDLE) & ~rst;
  assign req0_ready = idle & req0_valid & ~grant1;
  assign req1_ready = idle & grant1;
  assign busy       = (state_reg != IDLE) & ~rst;
  assign resp_valid = resp_valid_reg;
  assign resp_id    = id_reg;
  assign resp_res   = res_reg;
  assign ops_done   = ops_done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      op_a_reg       <= 32'd0;
      op_b_reg       <= 32'd0;
      res_reg        <= 32'd0;
      id_reg         <= 1'b0;
      last_grant_reg <= ~PRIO_INIT;
      resp_valid_reg <= 1'b0;
      ops_done_reg   <= 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0_valid | req1_valid) begin
            op_a_reg  <= grant1 ? req1_a : req0_a;
            op_b_reg  <= grant1 ? req1_b : req0_b;
            id_reg    <= grant1;
            state_reg <= CALC;
          end
        end
        CALC: begin
          res_reg        <= core_res;
          resp_valid_reg <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            last_grant_reg <= id_reg;
            ops_done_reg   <= ops_done_reg + 16'd1;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
